axis_frame_rr_arbiter: RTL and testbench



---
 rtl/axis_frame_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_axis_frame_rr_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_rr_arbiter.sv
// Frame-aware round-robin arbiter: merges S_COUNT AXI4-Stream sources onto one
// sink without interleaving frames. A port holds the grant from its first
// accepted beat until its tlast beat is accepted; priority then rotates.
module axis_frame_rr_arbiter #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int LAST_ENABLE = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_axis_tvalid,
    output logic [S_COUNT-1:0]             s_axis_tready,
    input  logic [S_COUNT-1:0]             s_axis_tlast,
    input  logic [S_COUNT*ID_WIDTH-1:0]    s_axis_tid,
    input  logic [S_COUNT*DEST_WIDTH-1:0]  s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,

    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [ID_WIDTH-1:0]            m_axis_tid,
    output logic [DEST_WIDTH-1:0]          m_axis_tdest,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,

    output logic                           grant_valid,
    output logic [$clog2(S_COUNT)-1:0]     grant_index,
    output logic [31:0]                    frame_count
);

    localparam int IDX_WIDTH = $clog2(S_COUNT);

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [31:0]            frame_count_q, frame_count_d;

    logic                   req_found;
    logic [IDX_WIDTH-1:0]   req_sel;
    logic [IDX_WIDTH-1:0]   cand_idx;
    int                     cand;
    logic                   frame_end;

    // Per-port views of the packed source buses so the output mux is a plain
    // array index on the grant.
    logic [DATA_WIDTH-1:0]  tdata_arr [S_COUNT];
    logic [KEEP_WIDTH-1:0]  tkeep_arr [S_COUNT];
    logic [ID_WIDTH-1:0]    tid_arr   [S_COUNT];
    logic [DEST_WIDTH-1:0]  tdest_arr [S_COUNT];
    logic [USER_WIDTH-1:0]  tuser_arr [S_COUNT];

    for (genvar i = 0; i < S_COUNT; i++) begin : g_unpack
        assign tdata_arr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign tkeep_arr[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        assign tid_arr[i]   = s_axis_tid[i*ID_WIDTH +: ID_WIDTH];
        assign tdest_arr[i] = s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        assign tuser_arr[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
    end

    // Round-robin scan: first requesting port upward from last_grant+1.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= S_COUNT) begin
                cand = cand - S_COUNT;
            end
            cand_idx = IDX_WIDTH'(cand);
            if (!req_found && s_axis_tvalid[cand_idx]) begin
                req_found = 1'b1;
                req_sel   = cand_idx;
            end
        end
    end

    // Output mux and ready steering; nothing is forwarded while idle.
    always_comb begin
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = tdata_arr[grant_q];
        m_axis_tkeep  = tkeep_arr[grant_q];
        m_axis_tid    = tid_arr[grant_q];
        m_axis_tdest  = tdest_arr[grant_q];
        m_axis_tuser  = tuser_arr[grant_q];
        // Without tlast support every beat is its own frame.
        m_axis_tlast  = (LAST_ENABLE != 0) ? s_axis_tlast[grant_q] : 1'b1;
        if (state_q == StActive) begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign frame_end = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Next-state: arbitrate in idle, release the grant on tlast accept.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        frame_count_d = frame_count_q;
        unique case (state_q)
            StIdle: begin
                if (req_found) begin
                    state_d      = StActive;
                    grant_d      = req_sel;
                    last_grant_d = req_sel;
                end
            end
            StActive: begin
                // A tvalid gap keeps the grant; only tlast releases it.
                if (frame_end) begin
                    state_d       = StIdle;
                    frame_count_d = frame_count_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset leaves port 0 with top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            last_grant_q  <= IDX_WIDTH'(S_COUNT - 1);
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign grant_valid = (state_q == StActive);
    assign grant_index = grant_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Scoreboard bench for axis_frame_rr_arbiter: random frames on four ports,
// a reset-mid-frame scenario, and a LAST_ENABLE=0 instance.
module tb_axis_frame_rr_arbiter;

    localparam int S   = 4;
    localparam int DW  = 16;
    localparam int KW  = 2;
    localparam int IW  = 4;
    localparam int DSW = 4;
    localparam int UW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic [S*DW-1:0]  s_tdata;
    logic [S*KW-1:0]  s_tkeep;
    logic [S-1:0]     s_tvalid;
    logic [S-1:0]     s_tready;
    logic [S-1:0]     s_tlast;
    logic [S*IW-1:0]  s_tid;
    logic [S*DSW-1:0] s_tdest;
    logic [S*UW-1:0]  s_tuser;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [IW-1:0]    m_tid;
    logic [DSW-1:0]   m_tdest;
    logic [UW-1:0]    m_tuser;
    logic             grant_valid;
    logic [1:0]       grant_index;
    logic [31:0]      frame_count;

    logic [DW-1:0]  s_data_a  [S];
    logic [KW-1:0]  s_keep_a  [S];
    logic [IW-1:0]  s_id_a    [S];
    logic [DSW-1:0] s_dest_a  [S];
    logic [UW-1:0]  s_user_a  [S];
    logic           s_valid_a [S];
    logic           s_last_a  [S];

    for (genvar g = 0; g < S; g++) begin : g_pack
        assign s_tdata[g*DW +: DW]   = s_data_a[g];
        assign s_tkeep[g*KW +: KW]   = s_keep_a[g];
        assign s_tid[g*IW +: IW]     = s_id_a[g];
        assign s_tdest[g*DSW +: DSW] = s_dest_a[g];
        assign s_tuser[g*UW +: UW]   = s_user_a[g];
        assign s_tvalid[g]           = s_valid_a[g];
        assign s_tlast[g]            = s_last_a[g];
    end

    axis_frame_rr_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW),
        .DEST_WIDTH(DSW), .USER_WIDTH(UW), .LAST_ENABLE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_index(grant_index), .frame_count(frame_count)
    );

    // Second instance: two ports, tlast ignored
    logic        rst2_n = 1'b0;
    logic [15:0] s2_tdata;
    logic [1:0]  s2_tkeep, s2_tvalid, s2_tready, s2_tlast, s2_tid, s2_tdest, s2_tuser;
    logic [7:0]  m2_tdata;
    logic        m2_tkeep, m2_tvalid, m2_tready, m2_tlast, m2_tid, m2_tdest, m2_tuser;
    logic        grant_valid2;
    logic [0:0]  grant_index2;
    logic [31:0] frame_count2;

    axis_frame_rr_arbiter #(
        .S_COUNT(2), .DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(1),
        .DEST_WIDTH(1), .USER_WIDTH(1), .LAST_ENABLE(0)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .s_axis_tdata(s2_tdata), .s_axis_tkeep(s2_tkeep), .s_axis_tvalid(s2_tvalid),
        .s_axis_tready(s2_tready), .s_axis_tlast(s2_tlast), .s_axis_tid(s2_tid),
        .s_axis_tdest(s2_tdest), .s_axis_tuser(s2_tuser),
        .m_axis_tdata(m2_tdata), .m_axis_tkeep(m2_tkeep), .m_axis_tvalid(m2_tvalid),
        .m_axis_tready(m2_tready), .m_axis_tlast(m2_tlast), .m_axis_tid(m2_tid),
        .m_axis_tdest(m2_tdest), .m_axis_tuser(m2_tuser),
        .grant_valid(grant_valid2), .grant_index(grant_index2), .frame_count(frame_count2)
    );

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
        logic           last;
        logic [1:0]     port;
    } beat_t;

    beat_t    src_q [S][$];
    beat_t    exp_q [$];
    logic     at_start [S];
    logic     mon_en = 1'b0;
    int       n_cmp = 0;
    int       n_fail = 0;
    int       frames_done = 0;
    int       total_frames = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Random frames per port, then the expected merged order: pure round robin
    // over ports that still have frames, starting after port S-1.
    task automatic build_stimulus();
        beat_t b;
        beat_t cp [S][$];
        int ptr;
        bit found;
        for (int p = 0; p < S; p++) begin
            int nf = $urandom_range(2, 5);
            total_frames += nf;
            for (int f = 0; f < nf; f++) begin
                int len = $urandom_range(1, 5);
                for (int i = 0; i < len; i++) begin
                    b.data = DW'($urandom);
                    b.keep = KW'($urandom);
                    b.id   = IW'($urandom);
                    b.dest = DSW'($urandom);
                    b.user = UW'($urandom);
                    b.last = (i == len - 1);
                    b.port = 2'(p);
                    src_q[p].push_back(b);
                end
            end
            cp[p] = src_q[p];
        end
        ptr = S - 1;
        forever begin
            found = 1'b0;
            for (int k = 1; k <= S; k++) begin
                int p = (ptr + k) % S;
                if (!found && cp[p].size() > 0) begin
                    found = 1'b1;
                    ptr = p;
                    do begin
                        b = cp[p].pop_front();
                        exp_q.push_back(b);
                    end while (!b.last);
                end
            end
            if (!found) break;
        end
    endtask

    task automatic present(input int p);
        beat_t b;
        if (src_q[p].size() > 0) b = src_q[p][0];
        else b = beat_t'($urandom);
        s_data_a[p] = b.data;
        s_keep_a[p] = b.keep;
        s_id_a[p]   = b.id;
        s_dest_a[p] = b.dest;
        s_user_a[p] = b.user;
        s_last_a[p] = b.last;
    endtask

    // Sources always offer a frame's first beat; mid-frame beats may gap.
    task automatic update_inputs(input logic [S-1:0] acc);
        for (int p = 0; p < S; p++) begin
            logic held;
            held = s_valid_a[p] && !acc[p];
            if (acc[p]) begin
                at_start[p] = src_q[p][0].last;
                void'(src_q[p].pop_front());
            end
            if (src_q[p].size() == 0) s_valid_a[p] = 1'b0;
            else if (at_start[p] || held) s_valid_a[p] = 1'b1;
            else s_valid_a[p] = ($urandom_range(0, 3) != 0);
            present(p);
        end
        m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_step();
        logic [S-1:0] acc;
        @(negedge clk);
        acc = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        update_inputs(acc);
    endtask

    // Monitor: pops the scoreboard on each accepted beat.
    initial begin
        int gap;
        beat_t e, got;
        logic [S-1:0] er;
        logic emv;
        gap = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                er = '0;
                if (grant_valid && m_tready) er[grant_index] = 1'b1;
                emv = grant_valid && s_tvalid[grant_index];
                check("ready_valid_steer", {s_tready, m_tvalid}, {er, emv});
                if (gap == 1) begin
                    check("idle_after_tlast", grant_valid, 1'b0);
                    check("frame_count", frame_count, frames_done);
                    gap = 2;
                end else if (gap == 2) begin
                    if (exp_q.size() > 0) check("regrant_latency", grant_valid, 1'b1);
                    gap = 0;
                end
                if (grant_valid && exp_q.size() > 0)
                    check("grant_index", grant_index, exp_q[0].port);
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h expected none", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        got = {m_tdata, m_tkeep, m_tid, m_tdest, m_tuser, m_tlast, grant_index};
                        check("beat", got, e);
                        if (e.last) begin
                            frames_done++;
                            gap = 1;
                        end
                    end
                end
            end else begin
                gap = 0;
            end
        end
    end

    initial begin
        int exp_port;
        int n_acc;
        for (int p = 0; p < S; p++) begin
            s_valid_a[p] = 1'b1;
            at_start[p]  = 1'b1;
            present(p);
        end
        m_tready  = 1'b1;
        s2_tdata  = {8'hB1, 8'hA0};
        s2_tkeep  = '0;
        s2_tvalid = '0;
        s2_tlast  = '0;
        s2_tid    = '0;
        s2_tdest  = '0;
        s2_tuser  = '0;
        m2_tready = 1'b0;
        build_stimulus();

        // Reset state, with requests and sink ready present
        #12;
        check("rst_grant_valid", grant_valid, 1'b0);
        check("rst_grant_index", grant_index, 2'd0);
        check("rst_frame_count", frame_count, 32'd0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_s_tready", s_tready, 4'b0);

        // Random traffic
        for (int p = 0; p < S; p++) s_valid_a[p] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        update_inputs('0);
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 20000 && exp_q.size() > 0; cyc++) drive_step();
        check("drained", exp_q.size(), 0);
        for (int p = 0; p < S; p++) s_valid_a[p] = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("total_frames", frame_count, total_frames);

        // Reset during beat 2 of a 5-beat frame on port 0
        @(posedge clk);
        #1;
        m_tready     = 1'b1;
        s_valid_a[0] = 1'b1;
        s_last_a[0]  = 1'b0;
        s_data_a[0]  = 16'h0101;
        @(posedge clk);
        #1;
        check("mid_grant_index", grant_index, 2'd0);
        check("mid_grant_valid", grant_valid, 1'b1);
        @(posedge clk);
        #1;
        s_data_a[0] = 16'h0202;
        @(negedge clk);
        check("mid_beat2_valid", {m_tvalid, m_tdata}, {1'b1, 16'h0202});
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_tvalid", m_tvalid, 1'b0);
        check("mid_rst_s_tready", s_tready, 4'b0);
        check("mid_rst_grant_valid", grant_valid, 1'b0);
        check("mid_rst_frame_count", frame_count, 32'd0);
        s_valid_a[1] = 1'b1;
        s_valid_a[2] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_priority", {grant_valid, grant_index}, {1'b1, 2'd0});

        // LAST_ENABLE=0: two always-valid ports alternate, one beat per frame
        s2_tvalid = 2'b11;
        m2_tready = 1'b1;
        @(negedge clk);
        rst2_n = 1'b1;
        exp_port = 0;
        n_acc = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("le0_valid_pattern", m2_tvalid, (i % 2 == 1));
            if (m2_tvalid && m2_tready) begin
                check("le0_port", grant_index2, exp_port);
                check("le0_data", m2_tdata, (exp_port == 1) ? 8'hB1 : 8'hA0);
                check("le0_last", m2_tlast, 1'b1);
                check("le0_count", frame_count2, n_acc);
                exp_port ^= 1;
                n_acc++;
            end
        end
        check("le0_frames", frame_count2, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
